// File: rtl/snake_cmd_arbiter_pkg.sv
// Shared encodings for the snake command arbiter: directions, key bit map,
// game state and the small direction helpers used by the filter.
package snake_cmd_arbiter_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_START = 4;
    localparam int KEY_PAUSE = 5;
    localparam int KEY_SPEED = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } game_state_t;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            DIR_UP:   opposite = DIR_DOWN;
            DIR_DOWN: opposite = DIR_UP;
            DIR_LEFT: opposite = DIR_RIGHT;
            default:  opposite = DIR_LEFT;
        endcase
    endfunction

    // {valid, dir}: lowest set press index wins
    function automatic logic [2:0] dir_pick(input logic [3:0] p);
        dir_pick = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (p[i]) dir_pick = {1'b1, 2'(i)};
    endfunction

endpackage

// File: rtl/snake_cmd_arbiter_cmd_fifo.sv
// DEPTH x 2-bit synchronous FIFO with flush; exposes both head and the most
// recently written entry (tail) so the caller can filter against it.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [1:0]             din,
    output logic [1:0]             head,
    output logic [1:0]             tail,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, last_ptr;
    logic          do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    // a pop in the same cycle frees the slot, so a full queue still accepts
    assign do_push  = push && (!full || do_pop);
    assign last_ptr = wr_ptr - 1'b1;
    assign head     = mem[rd_ptr];
    assign tail     = mem[last_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/snake_cmd_arbiter.sv
// Merges button and IR keys into queued snake steering commands and owns the
// idle/run/pause state. Define SNAKE_IR_EN to compile in the IR key path.
module snake_cmd_arbiter
    import snake_cmd_arbiter_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter bit         BTN_PRIO = 1'b1,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic                   pixel_clk,
    input  logic                   sys_rst,
    input  logic [5:0]             key_btn,
    input  logic [6:0]             key_ir,
    input  logic                   btn_speed,
    input  logic                   tick,
    input  logic                   game_over,
    output logic [1:0]             dir,
    output logic                   dir_upd,
    output logic                   run,
    output logic                   paused,
    output logic                   speed_step,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   overflow
);
    // bit 6 of each key vector is the speed key
    logic [6:0] btn_q, btn_qq, btn_press, ir_press;

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            btn_q  <= '0;
            btn_qq <= '0;
        end else begin
            btn_q  <= {btn_speed, key_btn};
            btn_qq <= btn_q;
        end
    end
    assign btn_press = btn_q & ~btn_qq;

`ifdef SNAKE_IR_EN
    logic [6:0] ir_q, ir_qq;

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            ir_q  <= '0;
            ir_qq <= '0;
        end else begin
            ir_q  <= key_ir;
            ir_qq <= ir_q;
        end
    end
    assign ir_press = ir_q & ~ir_qq;
`else
    logic ir_unused;
    assign ir_unused = ^key_ir;
    assign ir_press  = '0;
`endif

    logic [2:0] btn_pick, ir_pick, cand;
    logic [1:0] ref_dir, head, tail;
    logic       accept, start_p, pause_p, full, empty;

    assign btn_pick = dir_pick(btn_press[KEY_RIGHT:KEY_UP]);
    assign ir_pick  = dir_pick(ir_press[KEY_RIGHT:KEY_UP]);

    always_comb begin
        cand = btn_pick;
        if (ir_pick[2] && (!btn_pick[2] || !BTN_PRIO)) cand = ir_pick;
    end

    // filter against where the snake will be heading once the queue drains
    assign ref_dir = empty ? dir : tail;
    assign accept  = cand[2] && (cand[1:0] != ref_dir) && (cand[1:0] != opposite(ref_dir));
    assign start_p = btn_press[KEY_START] | ir_press[KEY_START];
    assign pause_p = btn_press[KEY_PAUSE] | ir_press[KEY_PAUSE];

    game_state_t state, state_nx;
    logic [1:0]  dir_nx;
    logic        flush, push, pop, ovf_nx;

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            dir        <= INIT_DIR;
            dir_upd    <= 1'b0;
            speed_step <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            dir        <= dir_nx;
            dir_upd    <= (dir_nx != dir);
            speed_step <= btn_press[KEY_SPEED] | ir_press[KEY_SPEED];
            overflow   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        flush    = 1'b0;
        pop      = tick && (state == ST_RUN) && !empty;
        push     = accept && (state == ST_RUN);
        ovf_nx   = overflow | (push && full && !pop);
        if (pop) dir_nx = head;
        case (state)
            ST_IDLE: if (start_p) begin
                state_nx = ST_RUN;
                flush    = 1'b1;
                dir_nx   = INIT_DIR;
            end
            ST_RUN:   if (pause_p) state_nx = ST_PAUSE;
            ST_PAUSE: if (pause_p || start_p) state_nx = ST_RUN;
            default:  state_nx = ST_IDLE;
        endcase
        if (game_over && state != ST_IDLE) state_nx = ST_IDLE;
    end

    assign run    = (state == ST_RUN);
    assign paused = (state == ST_PAUSE);

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (pixel_clk),
        .rst   (sys_rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (cand[1:0]),
        .head  (head),
        .tail  (tail),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_snake_cmd_arbiter.sv
// Randomised bench for snake_cmd_arbiter: two instances (button priority and
// IR priority) checked every cycle against a queue-level reference model.
module tb_snake_cmd_arbiter;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_DIR = 2'd3;
`ifdef SNAKE_IR_EN
    localparam bit IR = 1'b1;
`else
    localparam bit IR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst, btn_speed, tick, game_over;
    logic [5:0] key_btn;
    logic [6:0] key_ir;

    // index = BTN_PRIO value of the instance
    logic [1:0] o_dir [2];
    logic       o_upd [2], o_run [2], o_pau [2], o_spd [2], o_ovf [2];
    logic [2:0] o_cnt [2];

    snake_cmd_arbiter #(.DEPTH(DEPTH), .BTN_PRIO(1'b0), .INIT_DIR(INIT_DIR)) dut_p0 (
        .pixel_clk(clk), .sys_rst(sys_rst), .key_btn(key_btn), .key_ir(key_ir),
        .btn_speed(btn_speed), .tick(tick), .game_over(game_over),
        .dir(o_dir[0]), .dir_upd(o_upd[0]), .run(o_run[0]), .paused(o_pau[0]),
        .speed_step(o_spd[0]), .q_count(o_cnt[0]), .overflow(o_ovf[0]));

    snake_cmd_arbiter #(.DEPTH(DEPTH), .BTN_PRIO(1'b1), .INIT_DIR(INIT_DIR)) dut_p1 (
        .pixel_clk(clk), .sys_rst(sys_rst), .key_btn(key_btn), .key_ir(key_ir),
        .btn_speed(btn_speed), .tick(tick), .game_over(game_over),
        .dir(o_dir[1]), .dir_upd(o_upd[1]), .run(o_run[1]), .paused(o_pau[1]),
        .speed_step(o_spd[1]), .q_count(o_cnt[1]), .overflow(o_ovf[1]));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input int p, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (prio%0d): got %0d expected %0d at %0t", nm, p, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // state: 0 idle, 1 running, 2 paused
    int         m_st  [2] = '{0, 0};
    logic [1:0] m_dir [2] = '{INIT_DIR, INIT_DIR};
    logic [1:0] m_q   [2][DEPTH];
    int         m_n   [2] = '{0, 0};
    logic       m_upd [2] = '{0, 0};
    logic       m_spd [2] = '{0, 0};
    logic       m_ovf [2] = '{0, 0};
    logic [6:0] m_b1 = '0, m_b2 = '0, m_i1 = '0, m_i2 = '0;
    bit         started = 0;

    task automatic step_inst(input int p, input logic [6:0] bp, input logic [6:0] ip);
        int bd, id, c, r;
        logic [1:0] nd;
        bit acc, st_p, pa_p;
        bd = -1; id = -1;
        for (int k = 3; k >= 0; k--) begin
            if (bp[k]) bd = k;
            if (ip[k]) id = k;
        end
        if (bd >= 0 && id >= 0) c = (p == 1) ? bd : id;
        else                    c = (bd >= 0) ? bd : id;
        r   = (m_n[p] > 0) ? int'(m_q[p][m_n[p]-1]) : int'(m_dir[p]);
        acc = (c >= 0) && (c != r) && ((c ^ 1) != r);
        nd  = m_dir[p];
        if (m_st[p] == 1) begin
            if (tick && m_n[p] > 0) begin
                nd = m_q[p][0];
                for (int k = 0; k < DEPTH - 1; k++) m_q[p][k] = m_q[p][k+1];
                m_n[p]--;
            end
            if (acc) begin
                if (m_n[p] < DEPTH) begin
                    m_q[p][m_n[p]] = 2'(c);
                    m_n[p]++;
                end else m_ovf[p] = 1'b1;
            end
        end
        st_p = bp[4] | ip[4];
        pa_p = bp[5] | ip[5];
        if (game_over && m_st[p] != 0)        m_st[p] = 0;
        else if (m_st[p] == 0 && st_p) begin  m_st[p] = 1; m_n[p] = 0; nd = INIT_DIR; end
        else if (m_st[p] == 1 && pa_p)        m_st[p] = 2;
        else if (m_st[p] == 2 && (pa_p || st_p)) m_st[p] = 1;
        m_upd[p] = (nd != m_dir[p]);
        m_dir[p] = nd;
        m_spd[p] = bp[6] | ip[6];
    endtask

    task automatic model_step();
        logic [6:0] bp, ip;
        bp = m_b1 & ~m_b2;
        ip = IR ? (m_i1 & ~m_i2) : 7'd0;
        if (sys_rst) begin
            for (int p = 0; p < 2; p++) begin
                m_st[p] = 0; m_dir[p] = INIT_DIR; m_n[p] = 0;
                m_upd[p] = 0; m_spd[p] = 0; m_ovf[p] = 0;
            end
            m_b1 = '0; m_b2 = '0; m_i1 = '0; m_i2 = '0;
        end else begin
            for (int p = 0; p < 2; p++) step_inst(p, bp, ip);
            m_b2 = m_b1; m_b1 = {btn_speed, key_btn};
            m_i2 = m_i1; m_i1 = key_ir;
        end
        started = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int p = 0; p < 2; p++) begin
                check("dir",        p, 8'(o_dir[p]), 8'(m_dir[p]));
                check("dir_upd",    p, 8'(o_upd[p]), 8'(m_upd[p]));
                check("run",        p, 8'(o_run[p]), 8'(m_st[p] == 1));
                check("paused",     p, 8'(o_pau[p]), 8'(m_st[p] == 2));
                check("speed_step", p, 8'(o_spd[p]), 8'(m_spd[p]));
                check("q_count",    p, 8'(o_cnt[p]), 8'(m_n[p]));
                check("overflow",   p, 8'(o_ovf[p]), 8'(m_ovf[p]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int k);
        key_btn[k] = 1'b1;
        cyc(1);
        key_btn[k] = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; key_btn = '0; key_ir = '0; btn_speed = 1'b0;
        tick = 1'b0; game_over = 1'b0;
        cyc(3);
        sys_rst = 1'b0;
        cyc(1);
        check("rst_run", 1, 8'(o_run[1]), 8'd0);
        check("rst_dir", 1, 8'(o_dir[1]), 8'd3);
        check("rst_cnt", 1, 8'(o_cnt[1]), 8'd0);
        check("rst_ovf", 1, 8'(o_ovf[1]), 8'd0);

        press_btn(4);
        check("start_run", 1, 8'(o_run[1]), 8'd1);
        check("model_run", 1, 8'(m_st[1]), 8'd1);
        pulse_tick();
        check("empty_tick_upd", 1, 8'(o_upd[1]), 8'd0);

        press_btn(0);
        press_btn(1);
        check("rev_reject_cnt", 1, 8'(o_cnt[1]), 8'd1);
        pulse_tick();
        check("pop_dir", 1, 8'(o_dir[1]), 8'd0);
        check("pop_upd", 1, 8'(o_upd[1]), 8'd1);
        check("model_pop_dir", 1, 8'(m_dir[1]), 8'd0);
        cyc(1);
        check("pop_upd_end", 1, 8'(o_upd[1]), 8'd0);

        press_btn(2); press_btn(0); press_btn(2); press_btn(0); press_btn(2);
        check("full_cnt", 1, 8'(o_cnt[1]), 8'd4);
        check("full_ovf", 1, 8'(o_ovf[1]), 8'd1);
        key_btn[2] = 1'b1;
        cyc(1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0; key_btn[2] = 1'b0;
        check("pushpop_cnt", 1, 8'(o_cnt[1]), 8'd4);
        check("pushpop_dir", 1, 8'(o_dir[1]), 8'd2);

        press_btn(5);
        check("pause_paused", 1, 8'(o_pau[1]), 8'd1);
        pulse_tick(); pulse_tick();
        check("pause_dir", 1, 8'(o_dir[1]), 8'd2);
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        check("over_run", 1, 8'(o_run[1]), 8'd0);
        check("over_paused", 1, 8'(o_pau[1]), 8'd0);
        press_btn(4);
        check("restart_cnt", 1, 8'(o_cnt[1]), 8'd0);
        check("restart_dir", 1, 8'(o_dir[1]), 8'd3);

        btn_speed = 1'b1;
        cyc(2);
        check("speed_btn", 1, 8'(o_spd[1]), 8'd1);
        btn_speed = 1'b0;
        cyc(1);
        check("speed_end", 1, 8'(o_spd[1]), 8'd0);
        key_ir[6] = 1'b1; key_ir[0] = 1'b1;
        cyc(2);
        check("speed_ir", 1, 8'(o_spd[1]), 8'(IR));
        check("ir_dir_cnt", 1, 8'(o_cnt[1]), 8'(IR));
        key_ir = '0;
        cyc(1);
        pulse_tick();
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        press_btn(4);

        key_btn[0] = 1'b1; key_ir[1] = 1'b1;
        cyc(2);
        key_btn[0] = 1'b0; key_ir[1] = 1'b0;
        check("conflict_cnt_p1", 1, 8'(o_cnt[1]), 8'd1);
        check("conflict_cnt_p0", 0, 8'(o_cnt[0]), 8'd1);
        pulse_tick();
        check("conflict_dir_p1", 1, 8'(o_dir[1]), 8'd0);
        check("conflict_dir_p0", 0, 8'(o_dir[0]), IR ? 8'd1 : 8'd0);

        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 6; k++)
                if ($urandom_range(3) == 0) key_btn[k] = ~key_btn[k];
            for (int k = 0; k < 7; k++)
                if ($urandom_range(3) == 0) key_ir[k] = ~key_ir[k];
            if ($urandom_range(5) == 0) btn_speed = ~btn_speed;
            tick      = ($urandom_range(3) == 0);
            game_over = ($urandom_range(79) == 0);
            sys_rst   = ($urandom_range(599) == 0);
            cyc(1);
        end
        sys_rst = 1'b0; tick = 1'b0; game_over = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
